mem_arbiter: RTL and testbench

Arbitrates a single shared single-port synchronous memory between the core's instruction-fetch port (read-only) and its data port (load/store), so one RAM can back both `insn_*` and `norm_*` traffic. It sits between the core and the memory. It serialises requests through a small state machine with a one-outstanding-transaction req/ack handshake. Data requests have fixed priority over fetches, and a bounded starvation guard keeps fetch progressing.

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arbiter_arb_pick.sv | 44 ++++
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the instruction/data memory arbiter.
// Holds the FSM states, owner tags and counter widths.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_ACK   = 2'd3
  } arb_state_t;

  typedef enum logic {
    ARB_OWN_I = 1'b0,
    ARB_OWN_D = 1'b1
  } arb_owner_t;

  // MEM_LAT tops out at 4, so the wait counter only needs to reach 3.
  localparam int LAT_W    = 2;
  // STARVE_MAX tops out at 15.
  localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Fixed-priority pick (data first) with a saturating starvation counter
// that hands the grant to fetch after STARVE_MAX back-to-back data wins.
module arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_req,
  input  logic       d_req,
  input  logic       idle,
  input  logic       grant,
  output arb_owner_t winner
);

  logic [STARVE_W-1:0] starve_cnt_reg;
  logic                starved;

  assign starved = (starve_cnt_reg == STARVE_W'(STARVE_MAX));

  always_comb begin
    winner = ARB_OWN_I;
    if (d_req && !(i_req && starved)) begin
      winner = ARB_OWN_D;
    end
  end

  // A data grant with no fetch pending falls through to the idle clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      starve_cnt_reg <= '0;
    end else if (grant && (winner == ARB_OWN_I)) begin
      starve_cnt_reg <= '0;
    end else if (grant && i_req) begin
      if (!starved) begin
        starve_cnt_reg <= starve_cnt_reg + 1'b1;
      end
    end else if (idle && !i_req) begin
      starve_cnt_reg <= '0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between fetch and data ports,
// one transaction in flight, every output driven straight from a register.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_rw,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          m_en,
  output logic          m_rw,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  arb_state_t       state_reg;
  arb_owner_t       owner_reg;
  arb_owner_t       winner;
  logic             rw_reg;
  logic [LAT_W-1:0] lat_cnt_reg;
  logic             idle;
  logic             grant;

  logic             i_ack_reg;
  logic [DW-1:0]    i_rdata_reg;
  logic             d_ack_reg;
  logic [DW-1:0]    d_rdata_reg;
  logic             m_en_reg;
  logic             m_rw_reg;
  logic [AW-1:0]    m_addr_reg;
  logic [DW-1:0]    m_wdata_reg;

  assign idle  = (state_reg == ARB_IDLE);
  assign grant = idle && (i_req || d_req);

  arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .clk    (clk),
    .reset_n(reset_n),
    .i_req  (i_req),
    .d_req  (d_req),
    .idle   (idle),
    .grant  (grant),
    .winner (winner)
  );

  // m_en and m_rw are raised on the grant edge so they are live in ISSUE;
  // the WAIT state spans MEM_LAT cycles and captures on its last one.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg   <= ARB_IDLE;
      owner_reg   <= ARB_OWN_I;
      rw_reg      <= 1'b0;
      lat_cnt_reg <= '0;
      i_ack_reg   <= 1'b0;
      i_rdata_reg <= '0;
      d_ack_reg   <= 1'b0;
      d_rdata_reg <= '0;
      m_en_reg    <= 1'b0;
      m_rw_reg    <= 1'b0;
      m_addr_reg  <= '0;
      m_wdata_reg <= '0;
    end else begin
      case (state_reg)
        ARB_IDLE: begin
          if (grant) begin
            owner_reg <= winner;
            m_en_reg  <= 1'b1;
            state_reg <= ARB_ISSUE;
            if (winner == ARB_OWN_D) begin
              rw_reg      <= d_rw;
              m_rw_reg    <= d_rw;
              m_addr_reg  <= d_addr;
              m_wdata_reg <= d_wdata;
            end else begin
              rw_reg      <= 1'b0;
              m_rw_reg    <= 1'b0;
              m_addr_reg  <= i_addr;
              m_wdata_reg <= '0;
            end
          end
        end
        ARB_ISSUE: begin
          m_en_reg    <= 1'b0;
          m_rw_reg    <= 1'b0;
          lat_cnt_reg <= LAT_W'(MEM_LAT - 1);
          state_reg   <= ARB_WAIT;
        end
        ARB_WAIT: begin
          if (lat_cnt_reg == '0) begin
            state_reg <= ARB_ACK;
            if (owner_reg == ARB_OWN_D) begin
              d_ack_reg   <= 1'b1;
              d_rdata_reg <= rw_reg ? '0 : m_rdata;
            end else begin
              i_ack_reg   <= 1'b1;
              i_rdata_reg <= m_rdata;
            end
          end else begin
            lat_cnt_reg <= lat_cnt_reg - 1'b1;
          end
        end
        ARB_ACK: begin
          i_ack_reg <= 1'b0;
          d_ack_reg <= 1'b0;
          state_reg <= ARB_IDLE;
        end
        default: state_reg <= ARB_IDLE;
      endcase
    end
  end

  assign i_ack   = i_ack_reg;
  assign i_rdata = i_rdata_reg;
  assign d_ack   = d_ack_reg;
  assign d_rdata = d_rdata_reg;
  assign m_en    = m_en_reg;
  assign m_rw    = m_rw_reg;
  assign m_addr  = m_addr_reg;
  assign m_wdata = m_wdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: four arbiters (MEM_LAT 1..4, STARVE_MAX 2) share stimulus,
// each backed by its own RAM model; one instance is selected for checking.
module tb_mem_arbiter;

  localparam int NI = 4;

  logic        clk;
  logic        reset_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        d_req;
  logic        d_rw;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;

  logic        i_ack_a   [NI];
  logic [31:0] i_rdata_a [NI];
  logic        d_ack_a   [NI];
  logic [31:0] d_rdata_a [NI];
  logic        m_en_a    [NI];
  logic        m_rw_a    [NI];
  logic [31:0] m_addr_a  [NI];
  logic [31:0] m_wdata_a [NI];
  logic [31:0] m_rdata_a [NI];

  int n_checks = 0;
  int n_pass   = 0;
  int sel      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    logic [31:0] mem  [0:255];
    logic [31:0] pipe [0:3];

    mem_arbiter #(
      .AW(32), .DW(32), .MEM_LAT(gi + 1), .STARVE_MAX(2)
    ) u_dut (
      .clk    (clk),
      .reset_n(reset_n),
      .i_req  (i_req),
      .i_addr (i_addr),
      .i_ack  (i_ack_a[gi]),
      .i_rdata(i_rdata_a[gi]),
      .d_req  (d_req),
      .d_rw   (d_rw),
      .d_addr (d_addr),
      .d_wdata(d_wdata),
      .d_ack  (d_ack_a[gi]),
      .d_rdata(d_rdata_a[gi]),
      .m_en   (m_en_a[gi]),
      .m_rw   (m_rw_a[gi]),
      .m_addr (m_addr_a[gi]),
      .m_wdata(m_wdata_a[gi]),
      .m_rdata(m_rdata_a[gi])
    );

    initial begin
      for (int k = 0; k < 256; k++) mem[k] <= 32'hA500_0000 | 32'(k);
      mem[16] <= 32'hDEAD_BEEF;
      for (int k = 0; k < 4; k++) pipe[k] <= 32'h0;
    end

    // Read data emerges MEM_LAT cycles after the m_en cycle.
    always @(posedge clk) begin
      if (m_en_a[gi]) begin
        pipe[0] <= mem[m_addr_a[gi][7:0]];
        if (m_rw_a[gi]) mem[m_addr_a[gi][7:0]] <= m_wdata_a[gi];
      end
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end

    assign m_rdata_a[gi] = pipe[gi];
  end

  logic        s_i_ack, s_d_ack, s_m_en, s_m_rw;
  logic [31:0] s_i_rdata, s_d_rdata, s_m_addr, s_m_wdata;

  always_comb begin
    s_i_ack   = i_ack_a[sel];
    s_d_ack   = d_ack_a[sel];
    s_m_en    = m_en_a[sel];
    s_m_rw    = m_rw_a[sel];
    s_i_rdata = i_rdata_a[sel];
    s_d_rdata = d_rdata_a[sel];
    s_m_addr  = m_addr_a[sel];
    s_m_wdata = m_wdata_a[sel];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (lat=%0d)", name, act, exp, sel + 1);
  endtask

  // Cycle-level invariants on the selected instance.
  logic prev_m_en = 1'b0;
  always @(negedge clk) begin
    if (reset_n) begin
      chk("ack_exclusive", 32'(s_i_ack && s_d_ack), 32'd0);
      chk("m_en_single", 32'(s_m_en && prev_m_en), 32'd0);
      if (!s_m_en) chk("m_rw_unqualified", 32'(s_m_rw), 32'd0);
    end
    prev_m_en <= s_m_en;
  end

  typedef struct {
    logic        i;
    logic        d;
    logic        rw;
    logic        first_d;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic [31:0] i_exp;
    logic [31:0] d_exp;
  } vec_t;

  vec_t vecs [6];

  task automatic do_reset();
    reset_n = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_rw = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_i_ack"},   32'(s_i_ack), 32'd0);
    chk({tag, "_d_ack"},   32'(s_d_ack), 32'd0);
    chk({tag, "_m_en"},    32'(s_m_en),  32'd0);
    chk({tag, "_m_rw"},    32'(s_m_rw),  32'd0);
    chk({tag, "_m_addr"},  s_m_addr,     32'd0);
    chk({tag, "_m_wdata"}, s_m_wdata,    32'd0);
    chk({tag, "_i_rdata"}, s_i_rdata,    32'd0);
    chk({tag, "_d_rdata"}, s_d_rdata,    32'd0);
  endtask

  // Starts in an IDLE cycle (cycle 0); returns in the following IDLE cycle.
  task automatic run_row(input vec_t v, input int lat);
    int  nexp, nack, nmen, exp_cyc;
    logic own_d, exp_d;
    logic [31:0] exp_addr;
    nexp = int'(v.i) + int'(v.d);
    nack = 0;
    nmen = 0;
    i_req = v.i; i_addr = v.iaddr;
    d_req = v.d; d_rw = v.rw; d_addr = v.daddr; d_wdata = v.wdata;
    for (int cyc = 1; cyc <= 40 && nack < nexp; cyc++) begin
      @(posedge clk);
      #1;
      if (s_m_en) begin
        nmen++;
        exp_d    = (nmen == 1) ? v.first_d : !v.first_d;
        exp_cyc  = (nmen == 1) ? 1 : lat + 4;
        exp_addr = exp_d ? v.daddr : v.iaddr;
        chk("m_en_cycle", 32'(cyc), 32'(exp_cyc));
        chk("m_addr", s_m_addr, exp_addr);
        chk("m_rw", 32'(s_m_rw), 32'(exp_d && v.rw));
        if (exp_d && v.rw) chk("m_wdata", s_m_wdata, v.wdata);
      end
      if (s_i_ack || s_d_ack) begin
        nack++;
        own_d   = s_d_ack;
        exp_d   = (nack == 1) ? v.first_d : !v.first_d;
        exp_cyc = (nack == 1) ? lat + 2 : 2 * lat + 5;
        chk("ack_owner", 32'(own_d), 32'(exp_d));
        chk("ack_cycle", 32'(cyc), 32'(exp_cyc));
        if (own_d) chk("d_rdata", s_d_rdata, v.d_exp);
        else       chk("i_rdata", s_i_rdata, v.i_exp);
        if (own_d) d_req = 1'b0;
        else       i_req = 1'b0;
      end
    end
    chk("ack_count", 32'(nack), 32'(nexp));
    i_req = 1'b0; d_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    int   nack;
    logic exp_seq [6];

    //            i     d     rw    1st_d iaddr         daddr         wdata         i_exp         d_exp
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h00, 32'h0,         32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h00, 32'h20, 32'h12345678, 32'h0,         32'h0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h00, 32'h20, 32'h0,         32'h0,         32'h12345678};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h11, 32'h12, 32'h0,         32'hA5000011, 32'hA5000012};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h20, 32'h30, 32'hCAFEF00D, 32'h12345678, 32'h0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h00, 32'h30, 32'h0,         32'h0,         32'hCAFEF00D};

    sel = 0;
    do_reset();
    check_zero("reset");

    for (int r = 0; r < 6; r++) begin
      $display("vector %0d: i=%0d d=%0d rw=%0d", r, vecs[r].i, vecs[r].d, vecs[r].rw);
      run_row(vecs[r], 1);
    end

    // Both requests held: grants must go D,D,I,D,D,I, one every MEM_LAT+3 cycles.
    exp_seq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    i_req = 1'b1; i_addr = 32'h10;
    d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h12;
    nack = 0;
    for (int cyc = 1; cyc <= 60 && nack < 6; cyc++) begin
      @(posedge clk);
      #1;
      if (s_i_ack || s_d_ack) begin
        $display("starve ack %0d owner=%s cycle=%0d", nack, s_d_ack ? "D" : "I", cyc);
        chk("starve_owner", 32'(s_d_ack), 32'(exp_seq[nack]));
        chk("starve_cycle", 32'(cyc), 32'(3 + 4 * nack));
        if (s_d_ack) chk("starve_d_rdata", s_d_rdata, 32'hA5000012);
        else         chk("starve_i_rdata", s_i_rdata, 32'hDEADBEEF);
        nack++;
      end
    end
    chk("starve_ack_count", 32'(nack), 32'd6);
    i_req = 1'b0; d_req = 1'b0;

    // Latency sweep: read, write, read-back, and a fetch on each instance.
    for (int l = 1; l <= 4; l++) begin
      sel = l - 1;
      do_reset();
      v = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h40, 32'h0, 32'h0, 32'hA5000040};
      $display("sweep lat=%0d read", l);
      run_row(v, l);
      v = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h41, 32'h5A5A0000 | 32'(l), 32'h0, 32'h0};
      $display("sweep lat=%0d write", l);
      run_row(v, l);
      v = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h41, 32'h0, 32'h0, 32'h5A5A0000 | 32'(l), 32'h0};
      $display("sweep lat=%0d fetch", l);
      run_row(v, l);
    end

    // Reset while the MEM_LAT=3 instance sits in WAIT.
    sel = 2;
    do_reset();
    d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h13;
    @(posedge clk); #1;
    chk("midop_m_en", 32'(s_m_en), 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    d_req = 1'b0;
    @(posedge clk); #1;
    check_zero("midop");
    reset_n = 1'b1;
    nack = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(posedge clk); #1;
      if (s_i_ack || s_d_ack) nack++;
    end
    chk("midop_no_ack", 32'(nack), 32'd0);
    v = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h13, 32'h0, 32'h0, 32'hA5000013};
    $display("post-reset read lat=3");
    run_row(v, 3);
    v = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
    $display("post-reset fetch lat=3");
    run_row(v, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
